// File: rtl/hci_tcdm_bank_ts_adapter.sv
// ---------------------------------------------------------------------------
// hci_tcdm_bank_ts_adapter
//   Per-bank adapter between one log-interconnect slave port and one SRAM
//   bank. Every accepted request produces one response exactly MEM_LAT cycles
//   later. The ID travels alongside the request through a shift pipeline.
//   Test-and-set is done as a normal read followed by a locked write of
//   TS_WDATA. The write uses the latched address and byte enables. The
//   crossbar is stalled until the bank grants that write.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous flush of FSM and response pipeline
//   req_i/gnt_o          crossbar request / grant
//   add_i, wen_i, wdata_i, be_i, id_i, ts_i   crossbar request payload
//   r_valid_o, r_data_o, r_id_o               response (no backpressure)
//   mem_req_o/mem_gnt_i  SRAM request / grant
//   mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o   SRAM request payload
//   mem_rdata_i          SRAM read data, MEM_LAT cycles after a granted read
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | SRAM port mirrors the crossbar; grants follow mem_gnt_i
// TS_WR  | TS read done; issuing locked TS write, crossbar stalled
// ---------------------------------------------------------------------------
module hci_tcdm_bank_ts_adapter #(
  parameter int unsigned   AW       = 10,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   BW       = DW/8,
  parameter int unsigned   IW       = 8,
  parameter int            MEM_LAT  = 1,
  parameter logic [DW-1:0] TS_WDATA = {DW{1'b1}}
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [AW-1:0] add_i,
  input  logic          wen_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [BW-1:0] be_i,
  input  logic [IW-1:0] id_i,
  input  logic          ts_i,
  output logic          r_valid_o,
  output logic [DW-1:0] r_data_o,
  output logic [IW-1:0] r_id_o,
  output logic          mem_req_o,
  input  logic          mem_gnt_i,
  output logic [AW-1:0] mem_add_o,
  output logic          mem_wen_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [BW-1:0] mem_be_o,
  input  logic [DW-1:0] mem_rdata_i
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("hci_tcdm_bank_ts_adapter: MEM_LAT must be in 1..4");
  end

  typedef enum logic [0:0] {IDLE, TS_WR} state_e;

  state_e        state_q;
  logic [AW-1:0] ts_add_q;
  logic [BW-1:0] ts_be_q;

  logic          idle;
  logic          hs;
  logic          ts_start;

  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] rd_q;
  logic [IW-1:0]      id_q [MEM_LAT];

  assign idle     = (state_q == IDLE);
  // clear_i also blocks the grant so that no request is lost in the flush.
  assign gnt_o    = idle & mem_gnt_i & ~clear_i;
  assign hs       = req_i & gnt_o;
  assign ts_start = hs & ts_i & wen_i;

  // While clear_i is high nothing reaches the bank.
  // This also drops a pending TS write.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_add_o   = add_i;
    mem_wen_o   = wen_i;
    mem_wdata_o = wdata_i;
    mem_be_o    = be_i;
    if (!clear_i) begin
      if (idle) begin
        mem_req_o = req_i;
      end else begin
        mem_req_o   = 1'b1;
        mem_add_o   = ts_add_q;
        mem_wen_o   = 1'b0;
        mem_wdata_o = TS_WDATA;
        mem_be_o    = ts_be_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ts_add_q <= '0;
      ts_be_q  <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ts_start) begin
            state_q  <= TS_WR;
            ts_add_q <= add_i;
            ts_be_q  <= be_i;
          end
        end
        TS_WR: begin
          if (mem_gnt_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response pipeline: stage 0 captures the handshake.
  // The last stage lines up with the SRAM read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      rd_q  <= '0;
      for (int i = 0; i < MEM_LAT; i++) id_q[i] <= '0;
    end else begin
      vld_q[0] <= hs;
      rd_q[0]  <= wen_i;
      id_q[0]  <= id_i;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        rd_q[i]  <= rd_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
      if (clear_i) vld_q <= '0;
    end
  end

  assign r_valid_o = vld_q[MEM_LAT-1];
  assign r_id_o    = r_valid_o ? id_q[MEM_LAT-1] : '0;
  assign r_data_o  = (r_valid_o && rd_q[MEM_LAT-1]) ? mem_rdata_i : '0;

endmodule
